// File: rtl/cmos_wr_arbiter_pkg.sv
// Shared types and constants for the two-channel CMOS DDR write arbiter.
package cmos_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int BURST_LEN_DEF  = 16;
  localparam int BEAT_BYTES_DEF = 32;
  localparam int BURST_STEP     = BURST_LEN_DEF * BEAT_BYTES_DEF;

  localparam logic CH_CMOS1 = 1'b0;
  localparam logic CH_CMOS2 = 1'b1;

endpackage

// File: rtl/cmos_wr_arbiter_addr_gen.sv
// Per-channel frame-buffer address generator: write offset, double-buffer
// select and pending frame-restart flag.
module cmos_wr_addr_gen
  import cmos_wr_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 28'h0100000,
  parameter logic [ADDR_W-1:0] BASE        = 28'h0000000,
  parameter logic [ADDR_W-1:0] STEP        = ADDR_W'(BURST_STEP)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_apply_restart,
  input  logic              i_burst_done,
  output logic              o_pending,
  output logic              o_buf_idx,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_offset;
  logic              r_buf_idx;
  logic              r_pending;
  logic [ADDR_W-1:0] w_offset_inc;

  assign w_offset_inc = r_offset + STEP;

  // A pulse arriving on the very cycle a restart is applied re-arms the flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset  <= '0;
      r_buf_idx <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= i_frame_start | (r_pending & ~i_apply_restart);
      if (i_apply_restart) begin
        r_offset  <= '0;
        r_buf_idx <= ~r_buf_idx;
      end else if (i_burst_done) begin
        // An overlong frame wraps inside its own buffer.
        r_offset <= (w_offset_inc == FRAME_BYTES) ? '0 : w_offset_inc;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_buf_idx = r_buf_idx;
  assign o_addr    = BASE + (r_buf_idx ? FRAME_BYTES : '0) + r_offset;

endmodule

// File: rtl/cmos_wr_arbiter.sv
// Round-robin DDR write-burst scheduler for two CMOS capture channels with
// per-channel double-buffered frame addressing.
module cmos_wr_arbiter
  import cmos_wr_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                CNT_W       = 10,
  parameter int                BURST_LEN   = BURST_LEN_DEF,
  parameter int                BEAT_BYTES  = BEAT_BYTES_DEF,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 28'h0100000,
  parameter logic [ADDR_W-1:0] CH0_BASE    = 28'h0000000,
  parameter logic [ADDR_W-1:0] CH1_BASE    = 28'h0400000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_en,
  input  logic [1:0]        i_frame_start,
  input  logic [CNT_W-1:0]  i_fifo_cnt0,
  input  logic [CNT_W-1:0]  i_fifo_cnt1,
  output logic [1:0]        o_fifo_rd_en,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [7:0]        o_cmd_len,
  output logic              o_cmd_src,
  output logic              o_wdata_valid,
  input  logic              i_wdata_ready,
  output logic              o_wdata_last,
  output logic [1:0]        o_buf_idx,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);
  localparam int                BC_W = $clog2(BURST_LEN) + 1;

  state_e            r_state;
  logic              r_cmd_valid;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [7:0]        r_cmd_len;
  logic              r_cmd_src;
  logic              r_wdata_valid;
  logic              r_wdata_last;
  logic              r_busy;
  logic              r_rr_next;
  logic [BC_W-1:0]   r_beat_cnt;

  logic [1:0]        w_pending;
  logic [1:0]        w_buf_idx;
  logic [1:0]        w_apply;
  logic [1:0]        w_done;
  logic [1:0]        w_elig;
  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_addr1;
  logic              w_grant;
  logic              w_last_beat;
  logic [BC_W-1:0]   w_beat_inc;

  cmos_wr_addr_gen #(
    .ADDR_W(ADDR_W), .FRAME_BYTES(FRAME_BYTES), .BASE(CH0_BASE), .STEP(STEP)
  ) u_ag0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start[0]),
    .i_apply_restart(w_apply[0]), .i_burst_done(w_done[0]),
    .o_pending(w_pending[0]), .o_buf_idx(w_buf_idx[0]), .o_addr(w_addr0)
  );

  cmos_wr_addr_gen #(
    .ADDR_W(ADDR_W), .FRAME_BYTES(FRAME_BYTES), .BASE(CH1_BASE), .STEP(STEP)
  ) u_ag1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start[1]),
    .i_apply_restart(w_apply[1]), .i_burst_done(w_done[1]),
    .o_pending(w_pending[1]), .o_buf_idx(w_buf_idx[1]), .o_addr(w_addr1)
  );

  assign w_elig[0] = i_en[0] & (i_fifo_cnt0 >= CNT_W'(BURST_LEN)) & ~w_pending[0];
  assign w_elig[1] = i_en[1] & (i_fifo_cnt1 >= CNT_W'(BURST_LEN)) & ~w_pending[1];
  assign w_grant     = (&w_elig) ? r_rr_next : w_elig[CH_CMOS2];
  assign w_last_beat = (r_beat_cnt == BC_W'(BURST_LEN - 1));
  assign w_beat_inc  = r_beat_cnt + BC_W'(1);
  assign w_apply     = (r_state == ST_IDLE) ? w_pending : 2'b00;
  assign w_done      = ((r_state == ST_DATA) && i_wdata_ready && w_last_beat) ?
                       (r_cmd_src ? 2'b10 : 2'b01) : 2'b00;

  // Burst sequencer; reset aborts any burst in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cmd_valid   <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_len     <= 8'd0;
      r_cmd_src     <= 1'b0;
      r_wdata_valid <= 1'b0;
      r_wdata_last  <= 1'b0;
      r_busy        <= 1'b0;
      r_rr_next     <= CH_CMOS1;
      r_beat_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Pending restarts take this cycle; arbitration waits.
          if (!(|w_pending) && (|w_elig)) begin
            r_cmd_src   <= w_grant;
            r_cmd_addr  <= w_grant ? w_addr1 : w_addr0;
            r_cmd_len   <= 8'(BURST_LEN - 1);
            r_cmd_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_cmd_ready) begin
            r_cmd_valid   <= 1'b0;
            r_wdata_valid <= 1'b1;
            r_wdata_last  <= (BURST_LEN == 1);
            r_beat_cnt    <= '0;
            r_state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_wdata_ready) begin
            if (w_last_beat) begin
              r_wdata_valid <= 1'b0;
              r_wdata_last  <= 1'b0;
              r_beat_cnt    <= '0;
              r_rr_next     <= ~r_cmd_src;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_beat_cnt   <= w_beat_inc;
              r_wdata_last <= (w_beat_inc == BC_W'(BURST_LEN - 1));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rd_en  = (r_wdata_valid && i_wdata_ready) ?
                         (r_cmd_src ? 2'b10 : 2'b01) : 2'b00;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_addr    = r_cmd_addr;
  assign o_cmd_len     = r_cmd_len;
  assign o_cmd_src     = r_cmd_src;
  assign o_wdata_valid = r_wdata_valid;
  assign o_wdata_last  = r_wdata_last;
  assign o_buf_idx     = w_buf_idx;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_cmos_wr_arbiter.sv
// Self-checking bench for cmos_wr_arbiter: transaction-level frame-buffer
// model plus directed scenarios with literal expectations.
module tb_cmos_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, en_w, frame_start;
  logic [9:0]  fifo_cnt0, fifo_cnt1;
  logic        cmd_ready, wdata_ready;
  logic [1:0]  fifo_rd_en, buf_idx;
  logic        cmd_valid, cmd_src, wdata_valid, wdata_last, busy;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  w_fifo_rd_en, w_buf_idx;
  logic        w_cmd_valid, w_cmd_src, w_wdata_valid, w_wdata_last, w_busy;
  logic [27:0] w_cmd_addr;
  logic [7:0]  w_cmd_len;

  always #5 clk = ~clk;

  cmos_wr_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frame_start(frame_start),
    .i_fifo_cnt0(fifo_cnt0), .i_fifo_cnt1(fifo_cnt1), .o_fifo_rd_en(fifo_rd_en),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_addr(cmd_addr),
    .o_cmd_len(cmd_len), .o_cmd_src(cmd_src), .o_wdata_valid(wdata_valid),
    .i_wdata_ready(wdata_ready), .o_wdata_last(wdata_last), .o_buf_idx(buf_idx),
    .o_busy(busy)
  );

  cmos_wr_arbiter #(.FRAME_BYTES(28'h0000400)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_en(en_w), .i_frame_start(2'b00),
    .i_fifo_cnt0(fifo_cnt0), .i_fifo_cnt1(fifo_cnt1), .o_fifo_rd_en(w_fifo_rd_en),
    .o_cmd_valid(w_cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_addr(w_cmd_addr),
    .o_cmd_len(w_cmd_len), .o_cmd_src(w_cmd_src), .o_wdata_valid(w_wdata_valid),
    .i_wdata_ready(wdata_ready), .o_wdata_last(w_wdata_last), .o_buf_idx(w_buf_idx),
    .o_busy(w_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-buffer model: where each channel's next burst must land.
  localparam logic [27:0] FRAME = 28'h0100000;
  logic [27:0] m_off [2];
  logic        m_buf [2];
  logic        m_pend [2];
  logic        m_src;
  int          m_beats, cmd_cnt, done_cnt, pops0;
  logic [27:0] alog [$];
  logic        glog [$];
  logic [27:0] wlog [$];

  function automatic logic [27:0] base_of(input logic ch);
    return ch ? 28'h0400000 : 28'h0000000;
  endfunction

  initial forever begin
    logic [1:0]  exp_rd;
    logic [27:0] nxt;
    logic        s;
    @(negedge clk);
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_off[c] = '0; m_buf[c] = 1'b0; m_pend[c] = 1'b0;
      end
      m_src = 1'b0; m_beats = 0; cmd_cnt = 0; done_cnt = 0; pops0 = 0;
      alog.delete(); glog.delete(); wlog.delete();
    end else begin
      if (w_cmd_valid && cmd_ready) wlog.push_back(w_cmd_addr);
      for (int c = 0; c < 2; c++) if (frame_start[c]) m_pend[c] = 1'b1;
      exp_rd = (wdata_valid && wdata_ready) ? (cmd_src ? 2'b10 : 2'b01) : 2'b00;
      chk("fifo_rd_en", {30'd0, fifo_rd_en}, {30'd0, exp_rd});
      chk("busy", {31'd0, busy}, {31'd0, cmd_valid | wdata_valid});
      if (fifo_rd_en[0]) pops0++;
      if (cmd_valid) chk("cmd_len", {24'd0, cmd_len}, 32'd15);
      if (cmd_valid && cmd_ready) begin
        s = cmd_src;
        if (m_pend[s]) begin
          m_off[s] = '0; m_buf[s] = ~m_buf[s]; m_pend[s] = 1'b0;
        end
        chk("cmd_addr", {4'd0, cmd_addr},
            {4'd0, base_of(s) + (m_buf[s] ? FRAME : 28'd0) + m_off[s]});
        chk("buf_idx_at_cmd", {31'd0, buf_idx[s]}, {31'd0, m_buf[s]});
        alog.push_back(cmd_addr);
        glog.push_back(s);
        cmd_cnt++; m_beats = 0; m_src = s;
      end
      if (wdata_valid) begin
        chk("beat_in_burst", (m_beats < 16) ? 32'd1 : 32'd0, 32'd1);
        chk("wdata_last", {31'd0, wdata_last}, (m_beats == 15) ? 32'd1 : 32'd0);
        if (wdata_ready) begin
          m_beats++;
          if (m_beats == 16) begin
            nxt = m_off[m_src] + 28'h200;
            m_off[m_src] = (nxt == FRAME) ? 28'd0 : nxt;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 2'b00; en_w = 2'b00; frame_start = 2'b00;
    fifo_cnt0 = 10'd0; fifo_cnt1 = 10'd0; cmd_ready = 1'b1; wdata_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_cmds(input int target);
    int k = 0;
    while (cmd_cnt < target && k < 2000) begin tick(); k++; end
    chk("wait_cmds_timeout", (cmd_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 2000) begin tick(); k++; end
    chk("wait_done_timeout", (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input int b);
    int k = 0;
    while (!(wdata_valid && m_beats == b) && k < 2000) begin tick(); k++; end
    chk("wait_beats_timeout", (m_beats == b) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_addr", {4'd0, cmd_addr}, 32'd0);
    chk("rst_cmd_len", {24'd0, cmd_len}, 32'd0);
    chk("rst_wdata_valid", {31'd0, wdata_valid}, 32'd0);
    chk("rst_buf_idx", {30'd0, buf_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single channel, two bursts
    tick();
    en = 2'b01; fifo_cnt0 = 10'd32;
    wait_cmds(2); en = 2'b00; fifo_cnt0 = 10'd0;
    wait_done(2);
    chk("t1_ncmd", alog.size(), 32'd2);
    chk("t1_addr0", {4'd0, alog[0]}, 32'h0000000);
    chk("t1_addr1", {4'd0, alog[1]}, 32'h0000200);
    chk("t1_pops", pops0, 32'd32);

    // Both channels alternate
    do_reset();
    en = 2'b11; fifo_cnt0 = 10'd64; fifo_cnt1 = 10'd64;
    wait_cmds(4); en = 2'b00;
    wait_done(4);
    chk("t2_ncmd", alog.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_grant", {31'd0, glog[i]}, i % 2);
    chk("t2_addr1", {4'd0, alog[1]}, 32'h0400000);
    chk("t2_addr2", {4'd0, alog[2]}, 32'h0000200);
    chk("t2_addr3", {4'd0, alog[3]}, 32'h0400200);

    // frame_start mid-burst is deferred
    do_reset();
    en = 2'b01; fifo_cnt0 = 10'd64;
    wait_beats(5);
    frame_start = 2'b01; tick(); frame_start = 2'b00;
    wait_cmds(2); en = 2'b00;
    wait_done(2);
    chk("t3_addr0", {4'd0, alog[0]}, 32'h0000000);
    chk("t3_addr1", {4'd0, alog[1]}, 32'h0100000);
    chk("t3_buf_idx", {30'd0, buf_idx}, 32'd1);

    // Backpressure on both command and data
    do_reset();
    cmd_ready = 1'b0; en = 2'b01; fifo_cnt0 = 10'd64;
    k = 0;
    while (!cmd_valid && k < 50) begin tick(); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, cmd_valid}, 32'd1);
      chk("t4_hold_addr", {4'd0, cmd_addr}, 32'h0000000);
      chk("t4_hold_src", {31'd0, cmd_src}, 32'd0);
    end
    tick(); cmd_ready = 1'b1;
    tick(); en = 2'b00; fifo_cnt0 = 10'd0;
    k = 0;
    while (done_cnt < 1 && k < 200) begin wdata_ready = ~wdata_ready; tick(); k++; end
    wdata_ready = 1'b1;
    chk("t4_done", done_cnt, 32'd1);
    chk("t4_pops", pops0, 32'd16);

    // Offset wrap inside a small frame
    do_reset();
    en_w = 2'b01; fifo_cnt0 = 10'd64;
    k = 0;
    while (wlog.size() < 3 && k < 200) begin tick(); k++; end
    en_w = 2'b00;
    repeat (30) tick();
    chk("t5_ncmd", wlog.size(), 32'd3);
    chk("t5_addr0", {4'd0, wlog[0]}, 32'h000);
    chk("t5_addr1", {4'd0, wlog[1]}, 32'h200);
    chk("t5_addr2", {4'd0, wlog[2]}, 32'h000);
    chk("t5_buf_idx", {30'd0, w_buf_idx}, 32'd0);

    // Reset mid-burst
    do_reset();
    en = 2'b01; fifo_cnt0 = 10'd64;
    wait_beats(7);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rd_en", {30'd0, fifo_rd_en}, 32'd0);
    chk("t6_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("t6_cmd_addr", {4'd0, cmd_addr}, 32'd0);
    chk("t6_wdata_valid", {31'd0, wdata_valid}, 32'd0);
    chk("t6_wdata_last", {31'd0, wdata_last}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    tick(); rst = 1'b0;
    wait_cmds(1); en = 2'b00;
    wait_done(1);
    chk("t6_post_addr", {4'd0, alog[0]}, 32'h0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_wr_arbiter.md
Name: cmos_wr_arbiter

Overview:
- Schedules DDR write bursts for the two CMOS capture channels (cmos1, cmos2) in a shared memory-controller clock domain.
- Each channel's 16-bit pixels are already packed into a per-channel write FIFO upstream.
- Round-robin arbitration between the channels; one command plus its data beats in flight at a time.
- Generates frame-buffer addresses with per-channel double-buffering, so a downstream reader always has a complete frame in the other buffer.

Parameters:
- ADDR_W, 28, byte address width to the controller.
- CNT_W, 10, width of FIFO fill counts.
- BURST_LEN, 16, beats per write burst.
- BEAT_BYTES, 32, bytes per beat; address step per burst is BURST_LEN*BEAT_BYTES.
- FRAME_BYTES, 28'h0100000, byte stride of one frame buffer; must be a multiple of the burst step.
- CH0_BASE, 28'h0000000, base address of channel 0 buffer pair.
- CH1_BASE, 28'h0400000, base address of channel 1 buffer pair.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous reset, active-high.
- en  in  2  per-channel enable (bit0 = cmos1, bit1 = cmos2).
- frame_start  in  2  one-cycle pulse per channel, already synchronised to clk.
- fifo_cnt0  in  CNT_W  channel 0 FIFO fill level (beats).
- fifo_cnt1  in  CNT_W  channel 1 FIFO fill level (beats).
- fifo_rd_en  out  2  FIFO pop strobes.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  controller accepts command.
- cmd_addr  out  ADDR_W  burst start address.
- cmd_len  out  8  BURST_LEN-1.
- cmd_src  out  1  granted channel.
- wdata_valid  out  1  beat presented (data muxed externally by cmd_src).
- wdata_ready  in  1  controller accepts beat.
- wdata_last  out  1  final beat of burst.
- buf_idx  out  2  per-channel buffer currently being written.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset values: all outputs 0; offsets 0; round-robin pointer favours channel 0; pending-frame flags cleared.
- Reset mid-burst aborts immediately to IDLE. No further beats are issued; the controller side is reset by the same rst.
- FSM states: IDLE, CMD, DATA.
- Eligibility: channel i is eligible when en[i]=1, fifo_cnt_i >= BURST_LEN, and no frame restart is pending for i.
- IDLE:
  - First, apply any pending frame restarts: offset_i <= 0, buf_idx[i] toggles, flag cleared. This takes one cycle, and arbitration is suppressed in that cycle.
  - Otherwise, if any channel is eligible, grant it. With both eligible, grant the one opposite the last grant.
  - Register cmd_addr = CHi_BASE + buf_idx[i]*FRAME_BYTES + offset_i and cmd_src = i, then go to CMD.
- CMD: cmd_valid=1, fields held stable until cmd_ready. On cmd_valid & cmd_ready, go to DATA with beat_cnt = 0.
- DATA:
  - wdata_valid=1 and fifo_rd_en[cmd_src] = wdata_ready; no other bit is ever set.
  - beat_cnt increments on each accepted beat.
  - wdata_last = (beat_cnt == BURST_LEN-1).
  - On the last accepted beat: offset_i += BURST_LEN*BEAT_BYTES; update the RR pointer; go to IDLE.
- Offset wrap: if offset_i reaches FRAME_BYTES, it wraps to 0 without toggling buf_idx. An overlong frame overwrites its own buffer and never corrupts the other.
- frame_start pulse: sets the pending flag for that channel. A pulse during a burst on that channel is deferred until the burst ends; a burst is never split.
  - Two pulses before service collapse into one toggle.
  - Simultaneous pulses on both channels are serviced in the same IDLE cycle.
- en[i] deasserted mid-burst: the burst completes and the channel is then ineligible. frame_start still toggles buf_idx while disabled.
- Latency: from eligibility in IDLE, cmd_valid rises 1 cycle later. Minimum burst cost is 1 + 1 + BURST_LEN cycles with ready held high.
- Throughput bound: one burst in flight at a time; no command pipelining.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the burst step constant BURST_LEN*BEAT_BYTES;
  - the channel index constants CH_CMOS1=0, CH_CMOS2=1.
- One natural sub-module, cmos_wr_addr_gen, instantiated twice: holds offset, buf_idx and the pending flag, and produces a channel address.
- The arbiter FSM stays in the top.

Test Plan:
- Single channel: en=2'b01, fifo_cnt0=32, ready held 1 -> two bursts at 0x0000000 and 0x0000200, 16 fifo_rd_en[0] pulses each, wdata_last on the 16th beat.
- Both channels: fifo_cnt0=fifo_cnt1=64 -> grants alternate 0,1,0,1; ch1 first address 0x0400000.
- frame_start[0] pulsed at DATA beat 5 of a ch0 burst -> burst completes with 16 beats; next ch0 cmd_addr = 0x0100000 and buf_idx[0]=1.
- Backpressure: wdata_ready toggling 1/0 -> exactly 16 pops, beat_cnt frozen on ready=0; cmd fields held while cmd_ready=0 for 10 cycles.
- Wrap: FRAME_BYTES=0x400, 3 bursts without frame_start -> addresses 0x000, 0x200, 0x000, and buf_idx unchanged.
- rst asserted at DATA beat 7 -> next cycle all outputs 0, state IDLE; a post-reset burst starts at CH0_BASE.
